mem_access: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.

- **Non-memory instructions:** passes the write-back triple through unchanged.
- **Loads and stores:** runs a single-outstanding request/acknowledge transaction on the data bus.
- While a transaction is pending, it raises a stall request so the pipeline control block holds everything upstream.
- When the transaction completes, it presents the load or store result for one cycle.

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_access_lsu_fmt.sv | 79 +++++++
 rtl/mem_access.sv | 137 +++++++++++++
 tb/tb_mem_access.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: bus widths, reset level and load/store opcodes.
// Also holds the helpers that classify an ALU op as a load or a store.
package mem_access_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic                  RstEnable  = 1'b1;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
    localparam logic [RegBus-1:0]     ZeroWord   = '0;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

    function automatic logic is_load_op(input logic [AluOpBus-1:0] op);
        return (op == EXE_LB_OP)  || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
               (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
    endfunction

    function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_access_lsu_fmt.sv
// mem_lsu_fmt: combinational byte-lane select, store-data replication and load extraction.
// Half/word accesses use only addr[1] / no low bits, so misaligned addresses fold onto the aligned lanes.
module mem_lsu_fmt
    import mem_access_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop,
    input  logic [1:0]          addr_lo,
    input  logic [RegBus-1:0]   reg2,
    input  logic [RegBus-1:0]   rdata,
    output logic [3:0]          sel,
    output logic [RegBus-1:0]   wdata,
    output logic [RegBus-1:0]   rdata_fmt,
    output logic                is_load,
    output logic                is_store
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    assign is_load  = is_load_op(aluop);
    assign is_store = is_store_op(aluop);

    always_comb begin
        byte_v = '0;
        case (addr_lo)
            2'b00:   byte_v = rdata[31:24];
            2'b01:   byte_v = rdata[23:16];
            2'b10:   byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v   = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        byte_sel = 4'b1000 >> addr_lo;
        half_sel = addr_lo[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        sel       = '0;
        wdata     = ZeroWord;
        rdata_fmt = ZeroWord;
        case (aluop)
            EXE_LB_OP: begin
                sel       = byte_sel;
                rdata_fmt = {{24{byte_v[7]}}, byte_v};
            end
            EXE_LBU_OP: begin
                sel       = byte_sel;
                rdata_fmt = {24'h0, byte_v};
            end
            EXE_LH_OP: begin
                sel       = half_sel;
                rdata_fmt = {{16{half_v[15]}}, half_v};
            end
            EXE_LHU_OP: begin
                sel       = half_sel;
                rdata_fmt = {16'h0, half_v};
            end
            EXE_LW_OP: begin
                sel       = '1;
                rdata_fmt = rdata;
            end
            EXE_SB_OP: begin
                sel   = byte_sel;
                wdata = {4{reg2[7:0]}};
            end
            EXE_SH_OP: begin
                sel   = half_sel;
                wdata = {2{reg2[15:0]}};
            end
            EXE_SW_OP: begin
                sel   = '1;
                wdata = reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage; passes non-memory results through and runs one bus transaction per load/store.
// Optional MEM_ALIGN_CHECK_EN adds exc_misalign and suppresses misaligned half/word accesses.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  Rst_n,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [AluOpBus-1:0]   mem_aluop,
    input  logic [RegBus-1:0]     mem_addr,
    input  logic [RegBus-1:0]     mem_reg2,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [RegBus-1:0]     wb_wdata,
    output logic                  stallreq,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [RegBus-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [RegBus-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [RegBus-1:0]     bus_rdata
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  exc_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          fmt_sel;
    logic [RegBus-1:0]   fmt_wdata;
    logic [RegBus-1:0]   fmt_rdata;
    logic                is_load, is_store, is_mem;
    logic                misalign;
    logic [RegBus-1:0]   result;
    logic                in_reset;

    assign in_reset = (Rst_n == RstEnable);
    assign is_mem   = is_load | is_store;

    mem_lsu_fmt u_fmt (
        .aluop     (mem_aluop),
        .addr_lo   (mem_addr[1:0]),
        .reg2      (mem_reg2),
        .rdata     (bus_rdata),
        .sel       (fmt_sel),
        .wdata     (fmt_wdata),
        .rdata_fmt (fmt_rdata),
        .is_load   (is_load),
        .is_store  (is_store)
    );

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (mem_aluop)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign = mem_addr[0];
            EXE_LW_OP, EXE_SW_OP:             misalign = |mem_addr[1:0];
            default:                          misalign = 1'b0;
        endcase
    end
    assign exc_misalign = !in_reset && (state == IDLE) && misalign;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (in_reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= ZeroWord;
            bus_sel   <= '0;
            bus_wdata <= ZeroWord;
            result    <= ZeroWord;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (is_mem && !misalign) begin
                    bus_req   <= 1'b1;
                    bus_we    <= is_store;
                    bus_addr  <= {mem_addr[RegBus-1:2], 2'b00};
                    bus_sel   <= fmt_sel;
                    bus_wdata <= fmt_wdata;
                end
                BUSY: if (bus_ack) begin
                    bus_req <= 1'b0;
                    if (is_load) result <= fmt_rdata;
                end
                default: ;
            endcase
        end
    end

    // EX/MEM is held by stallreq, so mem_* still describe the pending op in BUSY and DONE.
    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        wb_wd     = mem_wd;
        wb_wreg   = mem_wreg;
        wb_wdata  = mem_wdata;
        if (in_reset) begin
            state_nxt = IDLE;
            wb_wd     = NOPRegAddr;
            wb_wreg   = 1'b0;
            wb_wdata  = ZeroWord;
        end else begin
            case (state)
                IDLE: if (is_mem) begin
                    wb_wreg  = 1'b0;
                    wb_wdata = ZeroWord;
                    if (!misalign) begin
                        stallreq  = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    stallreq = 1'b1;
                    wb_wreg  = 1'b0;
                    wb_wdata = ZeroWord;
                    if (bus_ack) state_nxt = DONE;
                end
                DONE: begin
                    wb_wreg   = is_load;
                    wb_wdata  = is_load ? result : ZeroWord;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand sequences and random loads/stores
// checked against an arithmetic model of lanes, replication and extension.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        exc_misalign;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_aluop (mem_aluop),
        .mem_addr  (mem_addr),
        .mem_reg2  (mem_reg2),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .stallreq  (stallreq),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_sel   (bus_sel),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .exc_misalign (exc_misalign)
`endif
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int unsigned waits;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        wreg;
        logic [31:0] wbdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: lanes counted from the MSB, sizes from the opcode, replication by multiplication.
    function automatic vec_t model(input logic [7:0] op, input logic [31:0] addr,
                                   input logic [31:0] reg2, input logic [31:0] rdata,
                                   input int unsigned waits);
        vec_t v;
        int unsigned k, h, size;
        logic [31:0] b, hw;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.waits = waits;
        size = (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) ? 1 :
               (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) ? 2 : 4;
        k  = addr % 4;
        h  = (addr / 2) % 2;
        b  = (rdata >> (8 * (3 - k))) % 256;
        hw = (rdata >> (16 * (1 - h))) % 65536;
        v.baddr = addr - k;
        v.we    = (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP);
        v.wreg  = !v.we;
        if (size == 1)      v.sel = 4'(8 >> k);
        else if (size == 2) v.sel = (h == 0) ? 4'hC : 4'h3;
        else                v.sel = 4'hF;
        v.bwdata = (size == 1) ? (reg2 % 256) * 32'h0101_0101 :
                   (size == 2) ? (reg2 % 65536) * 32'h0001_0001 : reg2;
        v.wbdata = 32'h0;
        case (op)
            EXE_LB_OP:  v.wbdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            EXE_LBU_OP: v.wbdata = b;
            EXE_LH_OP:  v.wbdata = (hw >= 32768) ? hw + 32'hFFFF_0000 : hw;
            EXE_LHU_OP: v.wbdata = hw;
            EXE_LW_OP:  v.wbdata = rdata;
            default:    v.wbdata = 32'h0;
        endcase
        return v;
    endfunction

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                input logic [31:0] rdata, input int unsigned waits, input logic [3:0] sel,
                                input logic we, input logic [31:0] baddr, input logic [31:0] bwdata,
                                input logic wreg, input logic [31:0] wbdata);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.waits = waits;
        v.sel = sel; v.we = we; v.baddr = baddr; v.bwdata = bwdata; v.wreg = wreg; v.wbdata = wbdata;
        return v;
    endfunction

    // Full transaction starting at the edge into IDLE; ends #1 after the edge into DONE.
    task automatic txn(input vec_t v, input logic [4:0] wd);
        @(posedge clk); #1;
        mem_aluop = v.op; mem_addr = v.addr; mem_reg2 = v.reg2;
        mem_wd = wd; mem_wreg = 1'b1; mem_wdata = $urandom; bus_ack = 1'b0;
        #1;
        chk("idle_stall", 32'(stallreq), 32'd1);
        chk("idle_wreg", 32'(wb_wreg), 32'd0);
        chk("idle_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        chk("busy_req", 32'(bus_req), 32'd1);
        chk("busy_stall", 32'(stallreq), 32'd1);
        chk("busy_we", 32'(bus_we), 32'(v.we));
        chk("busy_addr", bus_addr, v.baddr);
        chk("busy_sel", 32'(bus_sel), 32'(v.sel));
        if (v.we) chk("busy_wdata", bus_wdata, v.bwdata);
        for (int unsigned i = 0; i < v.waits; i++) begin
            @(posedge clk); #1;
            chk("wait_req", 32'(bus_req), 32'd1);
            chk("wait_stall", 32'(stallreq), 32'd1);
        end
        bus_ack = 1'b1; bus_rdata = v.rdata;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_stall", 32'(stallreq), 32'd0);
        chk("done_wreg", 32'(wb_wreg), 32'(v.wreg));
        if (v.wreg) begin
            chk("done_wd", 32'(wb_wd), 32'(wd));
            chk("done_wdata", wb_wdata, v.wbdata);
        end
    endtask

    logic [7:0] mem_ops [8];

    initial begin
        mem_ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                    EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

        vecs.push_back(mk(EXE_LW_OP,  32'h100, 32'h0,          32'hDEADBEEF, 0, 4'hF, 0, 32'h100, 32'h0,        1, 32'hDEADBEEF));
        vecs.push_back(mk(EXE_LB_OP,  32'h103, 32'h0,          32'h000000F0, 0, 4'h1, 0, 32'h100, 32'h0,        1, 32'hFFFFFFF0));
        vecs.push_back(mk(EXE_LBU_OP, 32'h103, 32'h0,          32'h000000F0, 1, 4'h1, 0, 32'h100, 32'h0,        1, 32'h000000F0));
        vecs.push_back(mk(EXE_SH_OP,  32'h202, 32'h0000ABCD,   32'h0,        2, 4'h3, 1, 32'h200, 32'hABCDABCD, 0, 32'h0));
        vecs.push_back(mk(EXE_LH_OP,  32'h100, 32'h0,          32'h80011234, 0, 4'hC, 0, 32'h100, 32'h0,        1, 32'hFFFF8001));
        vecs.push_back(mk(EXE_LHU_OP, 32'h102, 32'h0,          32'h80019234, 3, 4'h3, 0, 32'h100, 32'h0,        1, 32'h00009234));
        vecs.push_back(mk(EXE_SB_OP,  32'h301, 32'h123456A5,   32'h0,        0, 4'h4, 1, 32'h300, 32'hA5A5A5A5, 0, 32'h0));
        vecs.push_back(mk(EXE_SW_OP,  32'h404, 32'hCAFEF00D,   32'h0,        1, 4'hF, 1, 32'h404, 32'hCAFEF00D, 0, 32'h0));
        vecs.push_back(mk(EXE_LB_OP,  32'h100, 32'h0,          32'h7F000000, 0, 4'h8, 0, 32'h100, 32'h0,        1, 32'h0000007F));
`ifndef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(EXE_LW_OP,  32'h101, 32'h0,          32'h11223344, 0, 4'hF, 0, 32'h100, 32'h0,        1, 32'h11223344));
        vecs.push_back(mk(EXE_LH_OP,  32'h103, 32'h0,          32'hAABB7788, 0, 4'h3, 0, 32'h100, 32'h0,        1, 32'h00007788));
`endif

        // Reset state with non-zero upstream values so the reset gating is visible.
        Rst_n = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h5555AAAA;
        mem_aluop = EXE_LW_OP; mem_addr = 32'h104; mem_reg2 = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_sel", 32'(bus_sel), 32'd0);
        chk("rst_bwdata", bus_wdata, 32'h0);
        chk("rst_wd", 32'(wb_wd), 32'(NOPRegAddr));
        chk("rst_wreg", 32'(wb_wreg), 32'd0);
        chk("rst_wdata", wb_wdata, 32'h0);
        chk("rst_stall", 32'(stallreq), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_exc", 32'(exc_misalign), 32'd0);
`endif
        mem_aluop = EXE_NOP_OP;
        Rst_n = 1'b0;

        // ADD pass-through, then a few random non-memory ops; bus_req must stay low.
        @(posedge clk); #1;
        mem_aluop = 8'b0010_0000; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
        #1;
        chk("add_wd", 32'(wb_wd), 32'd5);
        chk("add_wreg", 32'(wb_wreg), 32'd1);
        chk("add_wdata", wb_wdata, 32'h1234);
        chk("add_stall", 32'(stallreq), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("pt_req", 32'(bus_req), 32'd0);
            mem_aluop = 8'($urandom_range(0, 8'hDF));
            mem_wd = 5'($urandom); mem_wreg = 1'($urandom); mem_wdata = $urandom;
            #1;
            chk("pt_wd", 32'(wb_wd), 32'(mem_wd));
            chk("pt_wreg", 32'(wb_wreg), 32'(mem_wreg));
            chk("pt_wdata", wb_wdata, mem_wdata);
            chk("pt_stall", 32'(stallreq), 32'd0);
        end

        foreach (vecs[i]) txn(vecs[i], 5'(i + 1));

        for (int i = 0; i < 40; i++) begin
            logic [7:0]  op;
            logic [31:0] a;
            op = mem_ops[$urandom_range(0, 7)];
            a  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            if (op == EXE_LW_OP || op == EXE_SW_OP) a[1:0] = 2'b00;
            if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) a[0] = 1'b0;
`endif
            txn(model(op, a, $urandom, $urandom, $urandom_range(0, 3)), 5'($urandom_range(1, 31)));
        end

        // Ack held high across DONE: only one transaction consumed, IDLE afterwards.
        @(posedge clk); #1;
        mem_aluop = EXE_LW_OP; mem_addr = 32'h108; mem_wd = 5'd3; mem_wreg = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
        @(posedge clk); #1;
        chk("hold_done_wdata", wb_wdata, 32'h13579BDF);
        chk("hold_done_stall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        mem_aluop = EXE_NOP_OP; mem_wdata = 32'h77; mem_wreg = 1'b1;
        #1;
        chk("hold_idle_req", 32'(bus_req), 32'd0);
        chk("hold_idle_stall", 32'(stallreq), 32'd0);
        chk("hold_idle_wdata", wb_wdata, 32'h77);
        bus_ack = 1'b0;

        // Reset while BUSY abandons the transaction; a later ack in IDLE is ignored.
        @(posedge clk); #1;
        mem_aluop = EXE_LW_OP; mem_addr = 32'h100; mem_wd = 5'd4;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        chk("rb_req", 32'(bus_req), 32'd1);
        chk("rb_stall", 32'(stallreq), 32'd1);
        Rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rb_rst_req", 32'(bus_req), 32'd0);
        chk("rb_rst_stall", 32'(stallreq), 32'd0);
        chk("rb_rst_addr", bus_addr, 32'h0);
        chk("rb_rst_sel", 32'(bus_sel), 32'd0);
        chk("rb_rst_wreg", 32'(wb_wreg), 32'd0);
        chk("rb_rst_wdata", wb_wdata, 32'h0);
        Rst_n = 1'b0; mem_aluop = EXE_NOP_OP; mem_wd = 5'd9; mem_wdata = 32'h55;
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        #1;
        chk("rb_ack_req", 32'(bus_req), 32'd0);
        chk("rb_ack_stall", 32'(stallreq), 32'd0);
        chk("rb_ack_wdata", wb_wdata, 32'h55);
        @(posedge clk); #1;
        chk("rb_ack_req2", 32'(bus_req), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned LW: one-cycle exception, no bus request, no write-back.
        @(posedge clk); #1;
        mem_aluop = EXE_LW_OP; mem_addr = 32'h101; mem_wd = 5'd6; mem_wreg = 1'b1;
        #1;
        chk("mis_exc", 32'(exc_misalign), 32'd1);
        chk("mis_stall", 32'(stallreq), 32'd0);
        chk("mis_wreg", 32'(wb_wreg), 32'd0);
        @(posedge clk); #1;
        mem_aluop = EXE_NOP_OP;
        #1;
        chk("mis_req", 32'(bus_req), 32'd0);
        chk("mis_exc_off", 32'(exc_misalign), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
